// File: rtl/adc_trig_reader.sv
// -----------------------------------------------------------------------------
// adc_trig_reader
//
// Receives the ADC trigger pulse from the ramp trigger generator, edge-detects
// it, optionally decimates it to every DECIM-th rising edge and runs one
// conversion/readout cycle of an external SPI-style ADC per accepted edge.
// The finished word is presented with a one-cycle valid strobe.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous, active-high reset
//   adc_trig   trigger input, synchronous to clk
//   adc_sdo    ADC serial data, MSB first
//   adc_cs_n   ADC chip select / convert start, active low
//   adc_sclk   ADC serial clock, idles low
//   adc_data   last completed sample (holds between strobes)
//   adc_valid  one-cycle strobe, adc_data updated this cycle
//   busy       high whenever the FSM is not in IDLE
//   trig_miss  one-cycle pulse for a rising edge dropped while busy
//
// Requires DATA_W >= 2, CLK_DIV >= 1, CNV_WAIT >= 1, QUIET >= 1, DECIM >= 1.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a rising trigger edge, decimation count runs
// CNV    | cs_n low, conversion time before the first SCLK edge
// SHIFT  | DATA_W SCLK periods, sample adc_sdo on each rising SCLK
// DONE   | one cycle with cs_n still low; strobe already issued
// QUIET  | cs_n high, minimum deselect time before the next start
// -----------------------------------------------------------------------------
module adc_trig_reader #(
    parameter int DATA_W   = 12,
    parameter int CLK_DIV  = 2,
    parameter int CNV_WAIT = 4,
    parameter int QUIET    = 2,
    parameter int DECIM    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_trig,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] adc_data,
    output logic              adc_valid,
    output logic              busy,
    output logic              trig_miss
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CNV   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_QUIET = 3'd4;

    // One down-counter times CNV, each SCLK half-period and QUIET, so it is
    // sized for the largest of the three load values.
    localparam int TMR_MAX_A = (CNV_WAIT > QUIET) ? CNV_WAIT : QUIET;
    localparam int TMR_MAX   = ((TMR_MAX_A > CLK_DIV) ? TMR_MAX_A : CLK_DIV) - 1;
    localparam int TMR_W     = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
    localparam int BIT_W     = $clog2(DATA_W);
    localparam int DCNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [TMR_W-1:0]  CNV_LOAD   = TMR_W'(CNV_WAIT - 1);
    localparam logic [TMR_W-1:0]  PH_LOAD    = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0]  QUIET_LOAD = TMR_W'(QUIET - 1);
    localparam logic [BIT_W-1:0]  BIT_LOAD   = BIT_W'(DATA_W - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DECIM - 1);

    logic [2:0]        state;
    logic [1:0]        trig_r;
    logic              trig_rise;
    logic [TMR_W-1:0]  tmr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DCNT_W-1:0] dcnt;
    logic [DATA_W-1:0] sreg;

    // History resets to all-ones so a trigger already high when reset is
    // released does not look like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_r <= 2'b11;
        end else begin
            trig_r <= {trig_r[0], adc_trig};
        end
    end

    assign trig_rise = trig_r[0] & ~trig_r[1];
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            bit_cnt   <= '0;
            dcnt      <= '0;
            sreg      <= '0;
            adc_cs_n  <= 1'b1;
            adc_sclk  <= 1'b0;
            adc_data  <= '0;
            adc_valid <= 1'b0;
            trig_miss <= 1'b0;
        end else begin
            adc_valid <= 1'b0;
            trig_miss <= trig_rise && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (trig_rise) begin
                        if (dcnt == DCNT_LAST) begin
                            dcnt     <= '0;
                            state    <= ST_CNV;
                            adc_cs_n <= 1'b0;
                            tmr      <= CNV_LOAD;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end

                ST_CNV: begin
                    if (tmr == '0) begin
                        state   <= ST_SHIFT;
                        tmr     <= PH_LOAD;
                        bit_cnt <= BIT_LOAD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                // Each bit: CLK_DIV cycles low, then CLK_DIV cycles high.
                // Data is captured on the edge that raises SCLK; the ADC
                // updates its output on the falling SCLK edge.
                ST_SHIFT: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end else if (!adc_sclk) begin
                        adc_sclk <= 1'b1;
                        sreg     <= {sreg[DATA_W-2:0], adc_sdo};
                        tmr      <= PH_LOAD;
                    end else begin
                        adc_sclk <= 1'b0;
                        tmr      <= PH_LOAD;
                        if (bit_cnt == '0) begin
                            // Strobe on entry to DONE so valid lines up with
                            // the first DONE cycle.
                            state     <= ST_DONE;
                            adc_data  <= sreg;
                            adc_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    adc_cs_n <= 1'b1;
                    state    <= ST_QUIET;
                    tmr      <= QUIET_LOAD;
                end

                ST_QUIET: begin
                    if (tmr == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_trig_reader.sv
// -----------------------------------------------------------------------------
// tb_adc_trig_reader
//
// Two instances share clock and reset: u_dut0 with default parameters and
// u_dut1 with DECIM=3. Each has a behavioural ADC that loads a word when cs_n
// falls and shifts it out MSB first on falling SCLK. A timeline model turns
// every trigger rising edge into per-cycle expectations (cs_n, sclk, busy,
// valid, miss, data), which are compared on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_adc_trig_reader;

    localparam int DW     = 12;
    localparam int CD     = 2;
    localparam int CW     = 4;
    localparam int QT     = 2;
    localparam int DECIM1 = 3;
    localparam int SH     = 2 * CD * DW;
    localparam int NCYC   = 8192;

    logic clk = 1'b0;
    logic rst;
    logic trig0, trig1, sdo0, sdo1;
    logic cs_n0, cs_n1, sclk0, sclk1;
    logic valid0, valid1, busy0, busy1, miss0, miss1;
    logic [DW-1:0] data0, data1;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    // timeline model, indexed [instance][cycle after edge n]
    bit            m_valid [2][NCYC];
    bit            m_miss  [2][NCYC];
    bit            m_cs    [2][NCYC];
    bit            m_busy  [2][NCYC];
    bit            m_sclk  [2][NCYC];
    logic [DW-1:0] m_word  [2][NCYC];
    int            m_ready [2];
    int            m_dcnt  [2];
    logic [DW-1:0] model_data [2];
    logic [DW-1:0] adc_word   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_trig_reader #(.DATA_W(DW), .CLK_DIV(CD), .CNV_WAIT(CW), .QUIET(QT), .DECIM(1)) u_dut0 (
        .clk(clk), .rst(rst), .adc_trig(trig0), .adc_sdo(sdo0),
        .adc_cs_n(cs_n0), .adc_sclk(sclk0), .adc_data(data0),
        .adc_valid(valid0), .busy(busy0), .trig_miss(miss0)
    );

    adc_trig_reader #(.DATA_W(DW), .CLK_DIV(CD), .CNV_WAIT(CW), .QUIET(QT), .DECIM(DECIM1)) u_dut1 (
        .clk(clk), .rst(rst), .adc_trig(trig1), .adc_sdo(sdo1),
        .adc_cs_n(cs_n1), .adc_sclk(sclk1), .adc_data(data1),
        .adc_valid(valid1), .busy(busy1), .trig_miss(miss1)
    );

    // behavioural ADCs
    initial begin : adc0
        logic [DW-1:0] sh;
        sdo0 = 1'b0;
        forever begin
            @(negedge cs_n0);
            sh   = adc_word[0];
            sdo0 = sh[DW-1];
            while (cs_n0 === 1'b0) begin
                @(negedge sclk0 or posedge cs_n0);
                if (cs_n0 === 1'b0) begin
                    sh   = sh << 1;
                    sdo0 = sh[DW-1];
                end
            end
        end
    end

    initial begin : adc1
        logic [DW-1:0] sh;
        sdo1 = 1'b0;
        forever begin
            @(negedge cs_n1);
            sh   = adc_word[1];
            sdo1 = sh[DW-1];
            while (cs_n1 === 1'b0) begin
                @(negedge sclk1 or posedge cs_n1);
                if (cs_n1 === 1'b0) begin
                    sh   = sh << 1;
                    sdo1 = sh[DW-1];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Conversion started at edge s: cs_n low E(s)..E(s+CW+SH), SCLK toggles in
    // the SH cycles after CNV, valid right after the last SCLK period, busy
    // through QUIET, and the next rise is acceptable from edge s+CW+SH+QT+2.
    task automatic model_start(input int i, input int s);
        for (int k = s; k <= s + CW + SH; k++) m_cs[i][k] = 1'b1;
        for (int k = s; k <= s + CW + SH + QT; k++) m_busy[i][k] = 1'b1;
        for (int k = 0; k < SH; k++) m_sclk[i][s + CW + k] = ((k % (2 * CD)) >= CD);
        m_valid[i][s + CW + SH] = 1'b1;
        m_word[i][s + CW + SH]  = adc_word[i];
        m_ready[i] = s + CW + SH + QT + 2;
    endtask

    // e is the edge at which the FSM evaluates the rise
    task automatic model_rise(input int i, input int e);
        int dec;
        dec = (i == 0) ? 1 : DECIM1;
        if (e + CW + SH + QT + 4 >= NCYC) return;
        if (e >= m_ready[i]) begin
            m_dcnt[i]++;
            if (m_dcnt[i] == dec) begin
                m_dcnt[i] = 0;
                model_start(i, e);
            end
        end else begin
            m_miss[i][e] = 1'b1;
        end
    endtask

    task automatic model_reset(input int c);
        for (int i = 0; i < 2; i++) begin
            for (int k = c; k < NCYC; k++) begin
                m_valid[i][k] = 1'b0;
                m_miss[i][k]  = 1'b0;
                m_cs[i][k]    = 1'b0;
                m_busy[i][k]  = 1'b0;
                m_sclk[i][k]  = 1'b0;
            end
            m_ready[i]    = 0;
            m_dcnt[i]     = 0;
            model_data[i] = '0;
        end
    endtask

    task automatic mon_inst(input int i, input logic v, input logic m, input logic b,
                            input logic csn, input logic sc, input logic [DW-1:0] d);
        int c;
        c = cyc;
        if (c >= NCYC) return;
        if (m_valid[i][c]) model_data[i] = m_word[i][c];
        chk($sformatf("valid%0d", i), 32'(v),   32'(m_valid[i][c]));
        chk($sformatf("miss%0d", i),  32'(m),   32'(m_miss[i][c]));
        chk($sformatf("busy%0d", i),  32'(b),   32'(m_busy[i][c]));
        chk($sformatf("cs_n%0d", i),  32'(csn), 32'(!m_cs[i][c]));
        chk($sformatf("sclk%0d", i),  32'(sc),  32'(m_sclk[i][c]));
        chk($sformatf("data%0d", i),  32'(d),   32'(model_data[i]));
    endtask

    always @(negedge clk) begin
        mon_inst(0, valid0, miss0, busy0, cs_n0, sclk0, data0);
        mon_inst(1, valid1, miss1, busy1, cs_n1, sclk1, data1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // called 1 time unit after edge c: the high level is sampled at c+1 and
    // the FSM sees the rise at c+2
    task automatic pulse(input int i, input int w);
        if (i == 0) trig0 = 1'b1; else trig1 = 1'b1;
        model_rise(i, cyc + 2);
        repeat (w) tick();
        if (i == 0) trig0 = 1'b0; else trig1 = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        model_reset(cyc);
        #1;
        chk("rst_async_cs_n0", 32'(cs_n0), 32'd1);
        chk("rst_async_sclk0", 32'(sclk0), 32'd0);
        chk("rst_async_data0", 32'(data0), 32'd0);
        repeat (hold) tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    initial begin : watchdog
        #(NCYC * 10);
        $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int c0, i, w, gap;
        rst         = 1'b1;
        trig0       = 1'b0;
        trig1       = 1'b0;
        adc_word[0] = '0;
        adc_word[1] = '0;
        model_reset(0);
        #1;
        chk("reset_cs_n", 32'(cs_n0), 32'd1);
        chk("reset_sclk", 32'(sclk0), 32'd0);
        chk("reset_data", 32'(data0), 32'd0);
        chk("reset_valid", 32'(valid0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_miss", 32'(miss0), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // single conversion
        adc_word[0] = 12'hA5C;
        c0 = cyc;
        pulse(0, 1);
        wait_until(c0 + 70);
        chk("single_word", 32'(data0), 32'h0A5C);

        // second trigger 20 cycles into a read is dropped
        adc_word[0] = 12'h123;
        c0 = cyc;
        pulse(0, 1);
        wait_until(c0 + 20);
        adc_word[0] = 12'h777;
        pulse(0, 1);
        wait_until(c0 + 120);
        chk("miss_keeps_first", 32'(data0), 32'h0123);

        // reset during bit 6 of SHIFT, then a clean read
        adc_word[0] = 12'h5A5;
        c0 = cyc;
        pulse(0, 1);
        wait_until(c0 + 2 + CW + 2 * CD * 6 + 2);
        do_reset(3);
        chk("abort_data", 32'(data0), 32'd0);
        adc_word[0] = 12'h3FF;
        c0 = cyc;
        pulse(0, 1);
        wait_until(c0 + 70);
        chk("after_abort_word", 32'(data0), 32'h03FF);

        // trigger held high across reset release: no edge
        tick();
        rst   = 1'b1;
        model_reset(cyc);
        trig0 = 1'b1;
        trig1 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (60) tick();
        chk("held_high_busy0", 32'(busy0), 32'd0);
        chk("held_high_busy1", 32'(busy1), 32'd0);
        trig0 = 1'b0;
        trig1 = 1'b0;
        repeat (5) tick();

        // back-to-back at minimum spacing, then one cycle too close
        adc_word[0] = 12'h001;
        c0 = cyc;
        pulse(0, 1);
        wait_until(c0 + 2 + CW + SH + QT);
        adc_word[0] = 12'h800;
        pulse(0, 1);
        wait_until(c0 + 2 + CW + SH + QT + 70);
        chk("b2b_second_word", 32'(data0), 32'h0800);

        adc_word[0] = 12'h0F0;
        c0 = cyc;
        pulse(0, 1);
        wait_until(c0 + 1 + CW + SH + QT);
        adc_word[0] = 12'hBAD;
        pulse(0, 1);
        wait_until(c0 + 130);
        chk("tight_spacing_word", 32'(data0), 32'h00F0);

        // DECIM=3: six rises 100 cycles apart convert on the 3rd and 6th
        for (int k = 0; k < 6; k++) begin
            adc_word[1] = DW'($urandom);
            c0 = cyc;
            pulse(1, 1);
            wait_until(c0 + 100);
            if (k == 2 || k == 5) chk("decim_word", 32'(data1), 32'(adc_word[1]));
        end

        // randomized triggers on both instances
        for (int k = 0; k < 40; k++) begin
            i   = int'($urandom_range(0, 1));
            w   = int'($urandom_range(1, 3));
            gap = int'($urandom_range(w + 1, 90));
            adc_word[i] = DW'($urandom);
            c0 = cyc;
            pulse(i, w);
            wait_until(c0 + gap);
        end
        repeat (150) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
